// File: rtl/sal_wr_arb.sv
// Round-robin DDR2 write-grant arbiter gated by buffered-burst credits and tCCD spacing; grant 1 cycle after eligibility.
// Requests are held until granted; hold_i or zero credits stall grants. SAL_WR_ARB_TWTR_EN adds the tWTR read block.
module sal_wr_arb #(
  parameter int NUM_REQ    = 4,
  parameter int CREDIT_MAX = 8,
  parameter int TIMER_W    = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_i,
  input  logic                              hold_i,
  input  logic                              burst_in_i,
  input  logic [TIMER_W-1:0]                tccd_i,
  input  logic [TIMER_W-1:0]                twtr_i,
  output logic [NUM_REQ-1:0]                gnt_o,
  output logic                              wr_gnt_o,
  output logic [$clog2(CREDIT_MAX+1)-1:0]   credits_o,
  output logic                              rd_block_o,
  output logic                              ovf_err_o
);

  localparam int CW = $clog2(CREDIT_MAX + 1);
  localparam int PW = $clog2(NUM_REQ);
  localparam logic [CW-1:0] CMAX = CW'(CREDIT_MAX);
  localparam logic [PW-1:0] LAST = PW'(NUM_REQ - 1);
  localparam logic [PW:0]   NREQ = (PW + 1)'(NUM_REQ);

  typedef enum logic [1:0] {IDLE, GNT, GAP} state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      win_q, win_d;
  logic [CW-1:0]      cred_q, cred_d;
  logic [TIMER_W-1:0] gap_q, gap_d;
  logic               ovf_q, ovf_d;
  logic [TIMER_W-1:0] tccd_eff;
  logic [PW-1:0]      pick;
  logic [PW:0]        idx;
  logic               found;
  logic               eligible;
  logic               issue;

  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr_q} + (PW + 1)'(k);
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_i[idx[PW-1:0]]) begin
        found = 1'b1;
        pick  = idx[PW-1:0];
      end
    end
  end

  assign eligible = found & ~hold_i & (cred_q != '0);
  assign tccd_eff = (tccd_i == '0) ? TIMER_W'(1) : tccd_i;
  assign issue    = (state_q == GNT);

  // The GNT cycle and the IDLE evaluation cycle count towards tCCD, so GAP lasts tccd-2 cycles.
  always_comb begin
    state_d = state_q;
    gnt_d   = '0;
    win_d   = win_q;
    ptr_d   = ptr_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        if (eligible) begin
          state_d = GNT;
          win_d   = pick;
          gnt_d   = NUM_REQ'(1) << pick;
        end
      end
      GNT: begin
        ptr_d = (win_q == LAST) ? '0 : win_q + 1'b1;
        if (tccd_eff <= TIMER_W'(2)) begin
          state_d = IDLE;
        end else begin
          state_d = GAP;
          gap_d   = tccd_eff - TIMER_W'(3);
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cred_d = cred_q;
    ovf_d  = ovf_q;
    if (burst_in_i && !issue) begin
      if (cred_q == CMAX) ovf_d  = 1'b1;
      else                cred_d = cred_q + 1'b1;
    end else if (!burst_in_i && issue && (cred_q != '0)) begin
      cred_d = cred_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      win_q   <= '0;
      ptr_q   <= '0;
      gap_q   <= '0;
      cred_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      gap_q   <= gap_d;
      cred_q  <= cred_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef SAL_WR_ARB_TWTR_EN
  logic [TIMER_W-1:0] twtr_q, twtr_d;

  always_comb begin
    twtr_d = twtr_q;
    if (issue)               twtr_d = twtr_i;
    else if (twtr_q != '0)   twtr_d = twtr_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) twtr_q <= '0;
    else     twtr_q <= twtr_d;
  end

  assign rd_block_o = |twtr_q;
`else
  logic unused_twtr;
  assign unused_twtr = ^twtr_i;
  assign rd_block_o  = 1'b0;
`endif

  assign gnt_o     = gnt_q;
  assign wr_gnt_o  = |gnt_q;
  assign credits_o = cred_q;
  assign ovf_err_o = ovf_q;

endmodule
